// File: rtl/cs_seq_pkg.sv
// rtl/cs_seq_pkg.sv - shared state codes, branch conditions and decode constants for the sequencer
package cs_seq_pkg;

  // Sequencer state codes, visible on the state output bus
  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_MEMWAIT = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  // MIR condition field encodings
  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_IF_N   = 3'b001;
  localparam logic [2:0] COND_IF_Z   = 3'b010;
  localparam logic [2:0] COND_IF_V   = 3'b011;
  localparam logic [2:0] COND_IF_C   = 3'b100;
  localparam logic [2:0] COND_IF_IMM = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  // Decode dispatch address is {prefix, opcode, suffix}
  localparam logic       DECODE_PREFIX = 1'b1;
  localparam logic [1:0] DECODE_SUFFIX = 2'b00;

  // Number of MEMWAIT cycles without an ack before the sequencer gives up
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/cs_address_sequencer_if.sv
// rtl/cs_address_sequencer_if.sv - MIR/memory/halt inputs and CSAR/status outputs of the sequencer
interface cs_address_sequencer_if #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_DECODEROP   = 8
);

  logic [DATAWIDTH_CONDITION-1:0]   CS_SEQ_Condition_InBus;
  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_SEQ_JumpAddress_InBus;
  logic [DATAWIDTH_DECODEROP-1:0]   CS_SEQ_DecodeOp_InBus;
  logic [3:0]                       CS_SEQ_Flags_InBus;
  logic                             CS_SEQ_IR13_In;
  logic                             CS_SEQ_MemRequest_In;
  logic                             CS_SEQ_MemAck_In;
  logic                             CS_SEQ_Halt_In;
  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_SEQ_CSAddress_OutBus;
  logic                             CS_SEQ_MIRLoad_Out;
  logic [1:0]                       CS_SEQ_State_OutBus;
  logic                             CS_SEQ_Error_Out;

  // Datapath/microcode side: drives MIR fields, memory handshake and halt
  modport master (
    output CS_SEQ_Condition_InBus, CS_SEQ_JumpAddress_InBus, CS_SEQ_DecodeOp_InBus,
           CS_SEQ_Flags_InBus, CS_SEQ_IR13_In, CS_SEQ_MemRequest_In,
           CS_SEQ_MemAck_In, CS_SEQ_Halt_In,
    input  CS_SEQ_CSAddress_OutBus, CS_SEQ_MIRLoad_Out, CS_SEQ_State_OutBus,
           CS_SEQ_Error_Out
  );

  // Sequencer side
  modport slave (
    input  CS_SEQ_Condition_InBus, CS_SEQ_JumpAddress_InBus, CS_SEQ_DecodeOp_InBus,
           CS_SEQ_Flags_InBus, CS_SEQ_IR13_In, CS_SEQ_MemRequest_In,
           CS_SEQ_MemAck_In, CS_SEQ_Halt_In,
    output CS_SEQ_CSAddress_OutBus, CS_SEQ_MIRLoad_Out, CS_SEQ_State_OutBus,
           CS_SEQ_Error_Out
  );

endinterface

// File: rtl/cs_next_addr_mux.sv
// rtl/cs_next_addr_mux.sv - combinational next control-store address selection
module cs_next_addr_mux
  import cs_seq_pkg::*;
#(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_DECODEROP   = 8
) (
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] csar,
  input  logic [DATAWIDTH_CONDITION-1:0]   cond,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] jump,
  input  logic [DATAWIDTH_DECODEROP-1:0]   decode_op,
  input  logic [3:0]                       flags,
  input  logic                             ir13,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr
);

  logic [DATAWIDTH_JUMPADDRESS-1:0] incr_addr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] decode_addr;
  logic [2:0]                       sel;
  logic                             flag_n;
  logic                             flag_z;
  logic                             flag_v;
  logic                             flag_c;

  // Sequential address wraps naturally at the address width
  assign incr_addr   = csar + DATAWIDTH_JUMPADDRESS'(1);
  assign decode_addr = DATAWIDTH_JUMPADDRESS'({DECODE_PREFIX, decode_op, DECODE_SUFFIX});
  assign sel         = 3'(cond);
  assign {flag_n, flag_z, flag_v, flag_c} = flags;

  // Pick the branch target according to the MIR condition field
  always_comb begin
    next_addr = incr_addr;
    case (sel)
      COND_NEXT:   next_addr = incr_addr;
      COND_IF_N:   next_addr = flag_n ? jump : incr_addr;
      COND_IF_Z:   next_addr = flag_z ? jump : incr_addr;
      COND_IF_V:   next_addr = flag_v ? jump : incr_addr;
      COND_IF_C:   next_addr = flag_c ? jump : incr_addr;
      COND_IF_IMM: next_addr = ir13 ? jump : incr_addr;
      COND_JUMP:   next_addr = jump;
      COND_DECODE: next_addr = decode_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/cs_address_sequencer.sv
// rtl/cs_address_sequencer.sv - microcode sequencer FSM and CSAR; optional CS_SEQ_MEMTIMEOUT_EN memory timeout
module cs_address_sequencer
  import cs_seq_pkg::*;
#(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_DECODEROP   = 8
) (
  input  logic                         CS_SEQ_CLOCK_50,
  input  logic                         CS_SEQ_ResetInLow_In,
  cs_address_sequencer_if.slave        bus
);

  state_t                           state;
  state_t                           state_nx;
  logic [DATAWIDTH_JUMPADDRESS-1:0] csar;
  logic [DATAWIDTH_JUMPADDRESS-1:0] csar_nx;
  logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr;
  logic                             mem_stall;

  // A request that is not acknowledged in the same cycle forces a wait state
  assign mem_stall = bus.CS_SEQ_MemRequest_In && !bus.CS_SEQ_MemAck_In;

  cs_next_addr_mux #(
    .DATAWIDTH_JUMPADDRESS (DATAWIDTH_JUMPADDRESS),
    .DATAWIDTH_CONDITION   (DATAWIDTH_CONDITION),
    .DATAWIDTH_DECODEROP   (DATAWIDTH_DECODEROP)
  ) u_next_addr_mux (
    .csar      (csar),
    .cond      (bus.CS_SEQ_Condition_InBus),
    .jump      (bus.CS_SEQ_JumpAddress_InBus),
    .decode_op (bus.CS_SEQ_DecodeOp_InBus),
    .flags     (bus.CS_SEQ_Flags_InBus),
    .ir13      (bus.CS_SEQ_IR13_In),
    .next_addr (next_addr)
  );

`ifdef CS_SEQ_MEMTIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       error;
  logic       error_nx;

  assign timeout = (wait_cnt == TIMEOUT_LIMIT - 8'd1);

  // Count unacknowledged MEMWAIT cycles, restarting on every entry into MEMWAIT
  always_ff @(posedge CS_SEQ_CLOCK_50 or negedge CS_SEQ_ResetInLow_In) begin
    if (!CS_SEQ_ResetInLow_In) begin
      wait_cnt <= 8'd0;
    end else if (state != ST_MEMWAIT && state_nx == ST_MEMWAIT) begin
      wait_cnt <= 8'd0;
    end else if (state == ST_MEMWAIT && !bus.CS_SEQ_MemAck_In) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge CS_SEQ_CLOCK_50 or negedge CS_SEQ_ResetInLow_In) begin
    if (!CS_SEQ_ResetInLow_In) begin
      error <= 1'b0;
    end else begin
      error <= error_nx;
    end
  end

  assign bus.CS_SEQ_Error_Out = error;
`else
  assign bus.CS_SEQ_Error_Out = 1'b0;
`endif

  // State and CSAR registers
  always_ff @(posedge CS_SEQ_CLOCK_50 or negedge CS_SEQ_ResetInLow_In) begin
    if (!CS_SEQ_ResetInLow_In) begin
      state <= ST_INIT;
      csar  <= '0;
    end else begin
      state <= state_nx;
      csar  <= csar_nx;
    end
  end

  // Next state and next CSAR; memory wait outranks halt, halt holds CSAR
  always_comb begin
    state_nx = state;
    csar_nx  = csar;
`ifdef CS_SEQ_MEMTIMEOUT_EN
    error_nx = error;
`endif
    case (state)
      ST_INIT: begin
        state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall) begin
          state_nx = ST_MEMWAIT;
        end else if (!bus.CS_SEQ_MemRequest_In && bus.CS_SEQ_Halt_In) begin
          state_nx = ST_HALT;
        end else begin
          csar_nx = next_addr;
        end
      end
      ST_MEMWAIT: begin
        if (bus.CS_SEQ_MemAck_In) begin
          state_nx = ST_RUN;
          csar_nx  = next_addr;
        end
`ifdef CS_SEQ_MEMTIMEOUT_EN
        else if (timeout) begin
          state_nx = ST_HALT;
          error_nx = 1'b1;
        end
`endif
      end
      ST_HALT: begin
        if (!bus.CS_SEQ_Halt_In) begin
          state_nx = ST_RUN;
        end
      end
      default: begin
        state_nx = ST_INIT;
      end
    endcase
  end

  assign bus.CS_SEQ_CSAddress_OutBus = csar;
  assign bus.CS_SEQ_State_OutBus     = state;
  assign bus.CS_SEQ_MIRLoad_Out      = (state == ST_RUN);

endmodule

// File: tb/tb_cs_address_sequencer.sv
// tb/tb_cs_address_sequencer.sv - directed and randomized self-checking bench for cs_address_sequencer
module tb_cs_address_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  cs_address_sequencer_if bus ();

  cs_address_sequencer dut (
    .CS_SEQ_CLOCK_50      (clk),
    .CS_SEQ_ResetInLow_In (rst_n),
    .bus                  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 init, 1 run, 2 memwait, 3 halt
  int m_state;
  int m_addr;
  int m_wait;
  int m_err;

  function automatic int ref_next(input int csar, input int cond, input int jump,
                                  input int op, input int flags, input int ir13);
    int seq;
    seq = (csar + 1) % 2048;
    case (cond)
      0: return seq;
      1, 2, 3, 4: return ((flags >> (4 - cond)) & 1) ? jump : seq;
      5: return ir13 ? jump : seq;
      6: return jump;
      default: return 1024 + op * 4;
    endcase
  endfunction

  task automatic model_edge();
    int na;
    int req;
    int ack;
    int halt;
    req  = int'(bus.CS_SEQ_MemRequest_In);
    ack  = int'(bus.CS_SEQ_MemAck_In);
    halt = int'(bus.CS_SEQ_Halt_In);
    na = ref_next(m_addr, int'(bus.CS_SEQ_Condition_InBus), int'(bus.CS_SEQ_JumpAddress_InBus),
                  int'(bus.CS_SEQ_DecodeOp_InBus), int'(bus.CS_SEQ_Flags_InBus),
                  int'(bus.CS_SEQ_IR13_In));
    case (m_state)
      0: m_state = 1;
      1: begin
        if (req == 1 && ack == 0) begin
          m_state = 2;
          m_wait  = 0;
        end else if (req == 0 && halt == 1) begin
          m_state = 3;
        end else begin
          m_addr = na;
        end
      end
      2: begin
        if (ack == 1) begin
          m_state = 1;
          m_addr  = na;
        end else begin
`ifdef CS_SEQ_MEMTIMEOUT_EN
          m_wait = m_wait + 1;
          if (m_wait == 255) begin
            m_state = 3;
            m_err   = 1;
          end
`endif
        end
      end
      default: if (halt == 0) m_state = 1;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mir(input int cond, input int jump, input int op, input int flags, input int ir13);
    bus.CS_SEQ_Condition_InBus   = 3'(cond);
    bus.CS_SEQ_JumpAddress_InBus = 11'(jump);
    bus.CS_SEQ_DecodeOp_InBus    = 8'(op);
    bus.CS_SEQ_Flags_InBus       = 4'(flags);
    bus.CS_SEQ_IR13_In           = 1'(ir13);
  endtask

  task automatic set_ctl(input int req, input int ack, input int halt);
    bus.CS_SEQ_MemRequest_In = 1'(req);
    bus.CS_SEQ_MemAck_In     = 1'(ack);
    bus.CS_SEQ_Halt_In       = 1'(halt);
  endtask

  task automatic expect_out(input string tag, input int st, input int addr);
    check({tag, "_state"}, 32'(bus.CS_SEQ_State_OutBus), 32'(st));
    check({tag, "_addr"}, 32'(bus.CS_SEQ_CSAddress_OutBus), 32'(addr));
    check({tag, "_mirload"}, 32'(bus.CS_SEQ_MIRLoad_Out), (st == 1) ? 32'd1 : 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    set_mir(0, 0, 0, 0, 0);
    set_ctl(0, 0, 0);
    tick();
    tick();
    expect_out("reset", 0, 0);
    check("reset_error", 32'(bus.CS_SEQ_Error_Out), 32'd0);

    // Release between edges; first edge enters RUN with CSAR still 0
    rst_n = 1'b1;
    expect_out("release", 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("seq", 1, i);
    end

    // Conditional branches
    set_mir(6, 10, 0, 0, 0);        tick(); expect_out("jump10", 1, 10);
    set_mir(2, 'h400, 0, 4'b0100, 0); tick(); expect_out("z_taken", 1, 'h400);
    set_mir(6, 10, 0, 0, 0);        tick(); expect_out("jump10b", 1, 10);
    set_mir(2, 'h400, 0, 4'b1011, 0); tick(); expect_out("z_not", 1, 11);
    set_mir(7, 'h123, 'h2A, 0, 0);  tick(); expect_out("decode", 1, 'h4A8);
    set_mir(5, 'h123, 0, 0, 1);     tick(); expect_out("ir13_taken", 1, 'h123);
    set_mir(4, 'h055, 0, 4'b0001, 0); tick(); expect_out("c_taken", 1, 'h055);
    set_mir(3, 'h200, 0, 4'b1101, 0); tick(); expect_out("v_not", 1, 'h056);
    set_mir(1, 'h300, 0, 4'b1000, 0); tick(); expect_out("n_taken", 1, 'h300);
    set_mir(6, 'h7FF, 0, 0, 0);     tick(); expect_out("jump7ff", 1, 'h7FF);
    set_mir(0, 0, 0, 0, 0);         tick(); expect_out("wrap", 1, 0);

    // Memory wait with ack on the fourth cycle
    set_ctl(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("memwait", 2, 0);
    end
    set_ctl(1, 1, 0); tick(); expect_out("mem_ack", 1, 1);
    set_ctl(1, 1, 0); tick(); expect_out("mem_nostall", 1, 2);

    // Halt is ignored while waiting on memory
    set_ctl(1, 0, 1); tick(); expect_out("halt_memwait1", 2, 2);
    tick();           expect_out("halt_memwait2", 2, 2);
    set_ctl(1, 1, 1); tick(); expect_out("halt_ack", 1, 3);
    set_ctl(0, 0, 1); tick(); expect_out("halt_enter", 3, 3);
    tick();           expect_out("halt_hold", 3, 3);
    set_ctl(0, 0, 0); tick(); expect_out("halt_exit", 1, 3);
    tick();           expect_out("halt_resume", 1, 4);

`ifdef CS_SEQ_MEMTIMEOUT_EN
    set_ctl(1, 0, 0);
    tick();
    for (int i = 0; i < 254; i++) tick();
    expect_out("to_wait254", 2, 4);
    check("to_noerr", 32'(bus.CS_SEQ_Error_Out), 32'd0);
    tick();
    expect_out("to_halt", 3, 4);
    check("to_err", 32'(bus.CS_SEQ_Error_Out), 32'd1);
    set_ctl(0, 0, 0); tick();
    expect_out("to_resume", 1, 4);
    check("to_sticky", 32'(bus.CS_SEQ_Error_Out), 32'd1);
    tick();
`endif

    // Reset in the middle of a memory wait takes effect without a clock edge
    set_ctl(1, 0, 0); tick();
    check("pre_rst_state", 32'(bus.CS_SEQ_State_OutBus), 32'd2);
    rst_n = 1'b0;
    #1;
    expect_out("rst_midwait", 0, 0);
    check("rst_error", 32'(bus.CS_SEQ_Error_Out), 32'd0);
    set_ctl(0, 0, 0);
    tick();
    rst_n = 1'b1;
    m_state = 0;
    m_addr  = 0;
    m_wait  = 0;
    m_err   = 0;

    // Randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      set_mir(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)));
      set_ctl(($urandom_range(0, 9) < 3) ? 1 : 0, int'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 2) ? 1 : 0);
      model_edge();
      tick();
      expect_out("rand", m_state, m_addr);
      check("rand_error", 32'(bus.CS_SEQ_Error_Out), 32'(m_err));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cs_address_sequencer.md
CS_ADDRESS_SEQUENCER -- requirements
Module: cs_address_sequencer

Interface
REQ-001 SHALL have parameter DATAWIDTH_JUMPADDRESS, default 11, control-store address width.
REQ-002 SHALL have parameter DATAWIDTH_CONDITION, default 3, branch-condition field width.
REQ-003 SHALL have parameter DATAWIDTH_DECODEROP, default 8, opcode bits used for decode dispatch.
REQ-004 SHALL have port CS_SEQ_CLOCK_50  in  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port CS_SEQ_ResetInLow_In  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port CS_SEQ_Condition_InBus  in  DATAWIDTH_CONDITION  MIR condition field.
REQ-007 SHALL have port CS_SEQ_JumpAddress_InBus  in  DATAWIDTH_JUMPADDRESS  MIR jump target.
REQ-008 SHALL have port CS_SEQ_DecodeOp_InBus  in  DATAWIDTH_DECODEROP  instruction op/op3 bits for dispatch.
REQ-009 SHALL have port CS_SEQ_Flags_InBus  in  4  PSR flags {n,z,v,c}.
REQ-010 SHALL have port CS_SEQ_IR13_In  in  1  instruction bit 13 (immediate select).
REQ-011 SHALL have port CS_SEQ_MemRequest_In  in  1  MIR RD or WR active this microinstruction.
REQ-012 SHALL have port CS_SEQ_MemAck_In  in  1  main memory transfer complete.
REQ-013 SHALL have port CS_SEQ_Halt_In  in  1  external halt request.
REQ-014 SHALL have port CS_SEQ_CSAddress_OutBus  out  DATAWIDTH_JUMPADDRESS  registered control-store address (CSAR).
REQ-015 SHALL have port CS_SEQ_MIRLoad_Out  out  1  MIR latch enable.
REQ-016 SHALL have port CS_SEQ_State_OutBus  out  2  current state code.
REQ-017 SHALL have port CS_SEQ_Error_Out  out  1  sticky memory-timeout flag.

Function
REQ-018 SHALL implement states INIT=00, RUN=01, MEMWAIT=10, HALT=11.
REQ-019 Next address SHALL be: cond 000 CSAR+1; 001/010/011/100 Jump if n/z/v/c else CSAR+1; 101 Jump if IR13 else CSAR+1; 110 Jump; 111 {1'b1, DecodeOp, 2'b00}.
REQ-020 CSAR+1 SHALL wrap from all-ones to 0 with no flag.
REQ-021 INIT SHALL go to RUN on the next edge, CSAR held at 0.
REQ-022 In RUN, MemRequest=1 with MemAck=0 SHALL go to MEMWAIT, CSAR held.
REQ-023 In RUN, MemRequest=1 with MemAck=1 in the same cycle SHALL advance CSAR with no wait state.
REQ-024 In RUN with no pending memory request, Halt_In=1 SHALL go to HALT, CSAR held; otherwise CSAR loads next address.
REQ-025 Memory wait SHALL take priority over Halt_In; Halt_In SHALL be ignored in MEMWAIT.
REQ-026 MEMWAIT SHALL return to RUN and load next address on the edge where MemAck=1.
REQ-027 HALT SHALL return to RUN (CSAR unchanged) on the edge where Halt_In=0.
REQ-028 MIRLoad_Out SHALL be combinational: 1 only in RUN.
REQ-029 Flags/IR13/DecodeOp SHALL be sampled only in the cycle the next address is loaded.

Reset
REQ-030 Reset low SHALL immediately force state INIT, CSAR 0, MIRLoad 0, Error 0, timeout counter 0, including mid-MEMWAIT.
REQ-031 Release SHALL be synchronous to the clock; first edge after release enters RUN.

Configuration
REQ-032 Macro CS_SEQ_MEMTIMEOUT_EN defined: 8-bit counter counts MEMWAIT cycles; at 255 cycles without MemAck, state SHALL go to HALT and Error_Out SHALL set until reset; counter clears on entering MEMWAIT.
REQ-033 Macro undefined: MEMWAIT waits indefinitely, no counter, Error_Out tied 0.

Structure
REQ-034 Shared package cs_seq_pkg SHALL hold state codes, condition codes 000-111, decode prefix/suffix constants, timeout limit 255.
REQ-035 Next-address selection SHALL be one combinational sub-module cs_next_addr_mux; FSM and CSAR in the top.

Verification
REQ-036 Reset release, cond=000 for 4 cycles -> CSAddress 0,0,1,2,3; State 00 then 01.
REQ-037 CSAR=10, cond=010, Jump=0x400, z=1 -> 0x400; z=0 -> 11; cond=111, DecodeOp=0x2A -> 0x4A8.
REQ-038 CSAR=0x7FF, cond=000 -> 0x000.
REQ-039 MemRequest=1, MemAck after 3 cycles -> CSAR held 3 cycles, MIRLoad 0, then advance; MemRequest and MemAck same cycle -> no stall.
REQ-040 Halt_In=1 during MEMWAIT -> stays MEMWAIT until ack, then HALT; Halt_In=0 -> RUN, CSAR unchanged.
REQ-041 With CS_SEQ_MEMTIMEOUT_EN, no ack for 255 cycles -> State 11, Error_Out=1 until reset; reset asserted mid-MEMWAIT -> CSAR 0, State 00 immediately.
